// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU request/result and Avalon-MM bus signals of the
// load/store unit. The "master" modport is the load/store unit itself (it
// masters the Avalon bus and produces the result). The "slave" modport is
// the surrounding CPU pipeline and memory.
interface mem_access_unit_if;
   logic        start;
   logic [5:0]  opcode;
   logic [31:0] base;
   logic [31:0] offset;
   logic [31:0] rt_value;
   logic        busy;
   logic        done;
   logic [31:0] load_data;
   logic        addr_error;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;

   modport master (
      input  start, opcode, base, offset, rt_value, avm_waitrequest, avm_readdata,
      output busy, done, load_data, addr_error,
      output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
   );

   modport slave (
      output start, opcode, base, offset, rt_value, avm_waitrequest, avm_readdata,
      input  busy, done, load_data, addr_error,
      input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS load/store unit. It forms ea = base + offset, runs one
// Avalon-MM read or write, and returns the aligned and extended load result,
// with LWL/LWR merged into the old rt value. All outputs are registered.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN: flag misaligned LW/SW/LH/LHU/SH
// and complete them without a bus cycle. When the macro is undefined, half
// accesses use ea[1] only and word accesses ignore ea[1:0].
module mem_access_unit (
   input  logic              clk,
   input  logic              reset,
   mem_access_unit_if.master bus
);
   localparam logic [5:0] OPCODE_LB  = 6'h20;
   localparam logic [5:0] OPCODE_LH  = 6'h21;
   localparam logic [5:0] OPCODE_LWL = 6'h22;
   localparam logic [5:0] OPCODE_LW  = 6'h23;
   localparam logic [5:0] OPCODE_LBU = 6'h24;
   localparam logic [5:0] OPCODE_LHU = 6'h25;
   localparam logic [5:0] OPCODE_LWR = 6'h26;
   localparam logic [5:0] OPCODE_SB  = 6'h28;
   localparam logic [5:0] OPCODE_SH  = 6'h29;
   localparam logic [5:0] OPCODE_SW  = 6'h2B;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2} state_t;

   function automatic logic is_legal(input logic [5:0] op);
      case (op)
         OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU, OPCODE_LW,
         OPCODE_LWL, OPCODE_LWR, OPCODE_SB, OPCODE_SH, OPCODE_SW: is_legal = 1'b1;
         default:                                                 is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic is_load(input logic [5:0] op);
      case (op)
         OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU,
         OPCODE_LW, OPCODE_LWL, OPCODE_LWR: is_load = 1'b1;
         default:                           is_load = 1'b0;
      endcase
   endfunction

   // Half accesses always sit on lane 0 or 2; ea[0] is either flagged or ignored.
   function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] k);
      case (op)
         OPCODE_LB, OPCODE_LBU, OPCODE_SB: lane_be = 4'b0001 << k;
         OPCODE_LH, OPCODE_LHU, OPCODE_SH: lane_be = 4'b0011 << {k[1], 1'b0};
         default:                          lane_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [1:0] k,
                                              input logic [31:0] rt);
      case (op)
         OPCODE_SB: lane_wdata = {24'd0, rt[7:0]} << {k, 3'b000};
         OPCODE_SH: lane_wdata = {16'd0, rt[15:0]} << {k[1], 4'b0000};
         OPCODE_SW: lane_wdata = rt;
         default:   lane_wdata = 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] format_load(input logic [5:0] op, input logic [1:0] k,
                                               input logic [31:0] rd, input logic [31:0] rt);
      logic [7:0]  d_b;
      logic [15:0] d_h;
      logic [4:0]  sh_l;
      d_b  = 8'(rd >> {k, 3'b000});
      d_h  = 16'(rd >> {k[1], 4'b0000});
      sh_l = {2'd3 - k, 3'b000};
      case (op)
         OPCODE_LB:  format_load = {{24{d_b[7]}}, d_b};
         OPCODE_LBU: format_load = {24'd0, d_b};
         OPCODE_LH:  format_load = {{16{d_h[15]}}, d_h};
         OPCODE_LHU: format_load = {16'd0, d_h};
         OPCODE_LWL: format_load = (rd << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l));
         OPCODE_LWR: format_load = (rd >> {k, 3'b000}) | (rt & ~(32'hFFFF_FFFF >> {k, 3'b000}));
         OPCODE_LW:  format_load = rd;
         default:    format_load = 32'd0;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [5:0]  op_q, op_d;
   logic [1:0]  k_q, k_d;
   logic [31:0] rt_q, rt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] load_data_q, load_data_d;
   logic        addr_error_q, addr_error_d;
   logic [31:0] avm_address_q, avm_address_d;
   logic        avm_read_q, avm_read_d;
   logic        avm_write_q, avm_write_d;
   logic [31:0] avm_writedata_q, avm_writedata_d;
   logic [3:0]  avm_byteenable_q, avm_byteenable_d;

   logic [31:0] ea_s;
   logic [1:0]  k_s;
   logic        accept_s;
   logic        misalign_s;

   assign ea_s     = bus.base + bus.offset;
   assign k_s      = ea_s[1:0];
   assign accept_s = (state_q == ST_IDLE) && bus.start && is_legal(bus.opcode);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
   // Classify the incoming request as misaligned from its opcode and ea[1:0].
   always_comb begin
      case (bus.opcode)
         OPCODE_LW, OPCODE_SW:              misalign_s = (k_s != 2'b00);
         OPCODE_LH, OPCODE_LHU, OPCODE_SH:  misalign_s = k_s[0];
         default:                           misalign_s = 1'b0;
      endcase
   end
`else
   assign misalign_s = 1'b0;
`endif

   // State and registered outputs; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         op_q             <= 6'd0;
         k_q              <= 2'd0;
         rt_q             <= 32'd0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         load_data_q      <= 32'd0;
         addr_error_q     <= 1'b0;
         avm_address_q    <= 32'd0;
         avm_read_q       <= 1'b0;
         avm_write_q      <= 1'b0;
         avm_writedata_q  <= 32'd0;
         avm_byteenable_q <= 4'd0;
      end else begin
         state_q          <= state_d;
         op_q             <= op_d;
         k_q              <= k_d;
         rt_q             <= rt_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         load_data_q      <= load_data_d;
         addr_error_q     <= addr_error_d;
         avm_address_q    <= avm_address_d;
         avm_read_q       <= avm_read_d;
         avm_write_q      <= avm_write_d;
         avm_writedata_q  <= avm_writedata_d;
         avm_byteenable_q <= avm_byteenable_d;
      end
   end

   // Next-state: accept in IDLE, wait out the slave stall in REQ, one RESP cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = misalign_s ? ST_RESP : ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (bus.avm_waitrequest) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output next-values: bus strobes live only in REQ, result is held until next RESP.
   always_comb begin
      op_d             = op_q;
      k_d              = k_q;
      rt_d             = rt_q;
      busy_d           = (state_d != ST_IDLE);
      done_d           = (state_d == ST_RESP);
      load_data_d      = load_data_q;
      addr_error_d     = addr_error_q;
      avm_address_d    = 32'd0;
      avm_read_d       = 1'b0;
      avm_write_d      = 1'b0;
      avm_writedata_d  = 32'd0;
      avm_byteenable_d = 4'd0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               op_d = bus.opcode;
               k_d  = k_s;
               rt_d = bus.rt_value;
               if (misalign_s) begin
                  load_data_d  = 32'd0;
                  addr_error_d = 1'b1;
               end else begin
                  avm_address_d    = {ea_s[31:2], 2'b00};
                  avm_read_d       = is_load(bus.opcode);
                  avm_write_d      = ~is_load(bus.opcode);
                  avm_writedata_d  = lane_wdata(bus.opcode, k_s, bus.rt_value);
                  avm_byteenable_d = lane_be(bus.opcode, k_s);
               end
            end else begin
               op_d = op_q;
            end
         end
         ST_REQ: begin
            if (bus.avm_waitrequest) begin
               avm_address_d    = avm_address_q;
               avm_read_d       = avm_read_q;
               avm_write_d      = avm_write_q;
               avm_writedata_d  = avm_writedata_q;
               avm_byteenable_d = avm_byteenable_q;
            end else begin
               load_data_d  = is_load(op_q) ? format_load(op_q, k_q, bus.avm_readdata, rt_q) : 32'd0;
               addr_error_d = 1'b0;
            end
         end
         ST_RESP: op_d = op_q;
         default: op_d = op_q;
      endcase
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.load_data      = load_data_q;
   assign bus.addr_error     = addr_error_q;
   assign bus.avm_address    = avm_address_q;
   assign bus.avm_read       = avm_read_q;
   assign bus.avm_write      = avm_write_q;
   assign bus.avm_writedata  = avm_writedata_q;
   assign bus.avm_byteenable = avm_byteenable_q;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store execution unit of the MIPS CPU, sitting directly downstream of the immediate sign-extension stage. It consumes the extended offset together with the base register, forms the effective address and runs one Avalon-MM style read or write transaction. It returns byte/half/word-aligned, sign- or zero-extended load data, with LWL/LWR merged into the old rt value. The CPU stalls on `busy` and writes back on `done`.

## Interface
Parameters: none.

- `clk` in 1 — sole clock; all state updates on rising edge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — request; sampled only in IDLE.
- `opcode` in 6 — one of OPCODE_LW/LB/LBU/LH/LHU/LWL/LWR/SW/SB/SH; any other opcode is ignored (no request accepted).
- `base` in 32 — rs value.
- `offset` in 32 — extended immediate from the sign-extension stage.
- `rt_value` in 32 — store data, or old rt for LWL/LWR merge.
- `busy` out 1 — high whenever state ≠ IDLE.
- `done` out 1 — one-cycle pulse; `load_data` and `addr_error` valid.
- `load_data` out 32 — final register value (0 for stores).
- `addr_error` out 1 — misaligned access (see Configuration).
- `avm_address` out 32 — word-aligned address, {ea[31:2], 2'b00}.
- `avm_read` out 1 — read strobe.
- `avm_write` out 1 — write strobe.
- `avm_writedata` out 32 — lane-shifted store data.
- `avm_byteenable` out 4 — bit k enables byte k, little-endian.
- `avm_waitrequest` in 1 — slave stall.
- `avm_readdata` in 32 — valid in the cycle the read completes.

## Operation
- Effective address `ea = base + offset`, modulo 2^32, latched with `opcode` and `rt_value` on acceptance. `k = ea[1:0]`.
- FSM states: IDLE, REQ, RESP.
  - IDLE→REQ on `start` with a legal, aligned opcode.
  - IDLE→RESP on `start` with a misaligned access; no bus cycle; `addr_error=1`, `load_data=0`.
  - REQ holds while `avm_waitrequest=1`. REQ→RESP on the first cycle with `avm_waitrequest=0`; `avm_readdata` is captured in that cycle.
  - RESP→IDLE unconditionally; `done=1` only in RESP.
- Read byteenables:
  - LW/LWL/LWR: 4'b1111.
  - LH/LHU: 4'b0011<<k.
  - LB/LBU: 4'b0001<<k.
- Loads, with `d = readdata >> 8k`:
  - LB sign-extends d[7:0]; LBU zero-extends d[7:0].
  - LH sign-extends d[15:0]; LHU zero-extends d[15:0].
  - LW returns readdata unchanged.
- LWL: `(readdata << 8(3−k)) | (rt & (2^(8(3−k))−1))`.
- LWR: `(readdata >> 8k) | (rt & ~(2^(32−8k)−1))`. At k=0 the rt mask is 0 and the full word is returned.
- Stores:
  - SW: writedata = rt, byteenable 4'b1111.
  - SH: writedata = rt[15:0]<<8k, byteenable 4'b0011<<k.
  - SB: writedata = rt[7:0]<<8k, byteenable 4'b0001<<k.
- `start` while busy is ignored; it is not queued.

## Timing
- Reset values: state IDLE, and every output 0 (`busy`, `done`, `load_data`, `addr_error`, `avm_*`).
- Reset during REQ or RESP returns to IDLE on the same edge. Strobes drop and no `done` is produced for the aborted access.
- `start` in cycle 0 → REQ in cycle 1 (strobe, address, byteenable and writedata all stable).
- With W wait cycles, `done` comes in cycle 2+W. Zero-wait latency is 2 cycles.
- All `avm_*` outputs are constant throughout REQ and deasserted in IDLE and RESP.
- Misaligned access: `done` with `addr_error` comes in cycle 1; `avm_*` stay idle.
- `load_data` holds its RESP value until the next RESP.

## Configuration
- `MEM_ACCESS_ALIGN_CHECK_EN` defined:
  - LW/SW with k≠0 is misaligned.
  - LH/LHU/SH with k[0]=1 is misaligned.
  - Misaligned accesses take the error path above.
- Undefined:
  - `addr_error` is tied 0 and no access is ever flagged misaligned.
  - LW/SW ignore k.
  - LH/LHU/SH use k&2'b10.
  - All requests take the normal REQ path.

## Test plan
- LW, base=0x1000, offset=0xFFFFFFFC, 0 waits, readdata=0x12345678 → avm_address=0xFFC, byteenable=1111, `done` in cycle 2, load_data=0x12345678.
- LB ea=0x2003, readdata=0x80AABBCC, 3 waits → byteenable=1000, `done` in cycle 5, load_data=0xFFFFFF80; LBU on the same access → 0x00000080.
- SH ea=0x2002, rt=0xDEADBEEF → avm_write=1, writedata=0xBEEF0000, byteenable=1100, load_data=0.
- LWL k=1, readdata=0x11223344, rt=0xAABBCCDD → 0x3344CCDD; LWR k=1 → 0xAA112233.
- With `MEM_ACCESS_ALIGN_CHECK_EN`: LW ea=0x3001 → no strobe, `done`+`addr_error` in cycle 1. Without the macro: read at 0x3000 and normal completion.
- Reset asserted in REQ during waits → next cycle all outputs 0 and `busy`=0. A new `start` then completes normally.
